ps2_key_status: RTL and testbench

//   Upstream input stage for game_2048_main. Receives PS/2 set-2 scan codes from a

---
 rtl/ps2_key_status.sv | 167 ++++++++++++++++
 tb/tb_ps2_key_status.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_status.sv
// PS/2 set-2 keyboard front end. It synchronises and filters the pins, receives
// 11-bit frames and keeps a held-key bitmap for the letters A..Z.
module ps2_key_status #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [25:0] key_status,
    output logic        any_key,
    output logic        scan_valid,
    output logic [7:0]  scan_code,
    output logic        frame_err
);
    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]    clk_s, dat_s;
    logic          flt;
    logic [FW-1:0] fcnt;
    logic          fall_stb, din;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] tcnt;
    logic          tmo;

    logic          brk, ext;
    logic [4:0]    idx;
    logic          hit;
    logic [25:0]   ks_nxt;

    // The filtered clock flips only after FILTER_LEN agreeing samples; the
    // strobe fires in the cycle that the flip to 0 is committed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s <= 2'b00;
            dat_s <= 2'b00;
            flt   <= 1'b1;
            fcnt  <= '0;
        end else begin
            clk_s <= {clk_s[0], ps2_clk};
            dat_s <= {dat_s[0], ps2_data};
            if (clk_s[1] != flt) begin
                if (fcnt == FMAX) begin
                    flt  <= clk_s[1];
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign fall_stb = flt & ~clk_s[1] & (fcnt == FMAX);
    assign din      = dat_s[1];
    assign tmo      = (state != S_IDLE) & ~fall_stb & (tcnt == TMAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_ok     <= 1'b0;
            tcnt       <= '0;
            scan_valid <= 1'b0;
            scan_code  <= '0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (tmo) begin
                state     <= S_IDLE;
                tcnt      <= '0;
                frame_err <= 1'b1;
            end else begin
                if (state == S_IDLE || fall_stb) tcnt <= '0;
                else                             tcnt <= tcnt + 1'b1;
                if (fall_stb) begin
                    case (state)
                        S_IDLE: if (!din) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                        S_DATA: begin
                            shreg   <= {din, shreg[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) state <= S_PAR;
                        end
                        S_PAR: begin
                            par_ok <= ^{din, shreg};
                            state  <= S_STOP;
                        end
                        default: begin
                            if (par_ok && din) begin
                                scan_valid <= 1'b1;
                                scan_code  <= shreg;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        hit = 1'b1;
        idx = 5'd0;
        case (scan_code)
            8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;
            8'h23: idx = 5'd3;   8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;
            8'h34: idx = 5'd6;   8'h33: idx = 5'd7;   8'h43: idx = 5'd8;
            8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
            8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;
            8'h4D: idx = 5'd15;  8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;
            8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;  8'h3C: idx = 5'd20;
            8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
            8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        ks_nxt = key_status;
        if (scan_valid && !ext && hit) ks_nxt[idx] = ~brk;
    end

    // Prefix flags survive only until the next accepted byte or any frame error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brk        <= 1'b0;
            ext        <= 1'b0;
            key_status <= '0;
            any_key    <= 1'b0;
        end else begin
            if (frame_err) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (scan_valid) begin
                if (scan_code == 8'hF0)      brk <= 1'b1;
                else if (scan_code == 8'hE0) ext <= 1'b1;
                else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
            end
            key_status <= ks_nxt;
            any_key    <= |ks_nxt;
        end
    end
endmodule

// File: tb/tb_ps2_key_status.sv
// Bench for ps2_key_status: directed scenarios plus random scan-code streams,
// checked against a byte-level keyboard model.
module tb_ps2_key_status;
    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [25:0] key_status;
    logic        any_key, scan_valid, frame_err;
    logic [7:0]  scan_code;

    ps2_key_status #(.FILTER_LEN(8), .TIMEOUT_CYCLES(5000)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_status(key_status), .any_key(any_key), .scan_valid(scan_valid),
        .scan_code(scan_code), .frame_err(frame_err)
    );

    always #20 clk = ~clk;

    int cyc = 0, last_fall = 0;
    int sv_cnt = 0, fe_cnt = 0, ovl = 0;
    int n_chk = 0, n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (!reset) begin
        sv_cnt <= sv_cnt + int'(scan_valid);
        fe_cnt <= fe_cnt + int'(frame_err);
        if (scan_valid && frame_err) ovl <= ovl + 1;
    end

    logic [7:0]  lut [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [25:0] m_ks = '0;
    logic [7:0]  m_code = '0;
    bit          m_brk = 0, m_ext = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_code = b;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            if (!m_ext)
                for (int i = 0; i < 26; i++) if (lut[i] == b) m_ks[i] = !m_brk;
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    // Drives the first nbits of a frame; an optional 200 ns low glitch is
    // inserted in the high phase of bit glitch_bit.
    task automatic send(input logic [7:0] b, input bit bp, input bit bs,
                        input int nbits, input int glitch_bit);
        logic [10:0] bits;
        bits = {~bs, (~^b) ^ bp, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            repeat (HALF/2) @(posedge clk);
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                repeat (3) @(posedge clk);
                ps2_clk = 1'b0;
                #200;
                ps2_clk = 1'b1;
                repeat (2) @(posedge clk);
            end else begin
                repeat (HALF/2) @(posedge clk);
            end
            ps2_clk = 1'b0;
            last_fall = cyc;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF/2) @(posedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic xfer(input logic [7:0] b, input bit bp, input bit bs, input int gl);
        int sv0, fe0;
        bit good;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        good = !bp && !bs;
        send(b, bp, bs, 11, gl);
        repeat (4) @(posedge clk);
        @(negedge clk);
        if (good) model_byte(b);
        else begin
            m_brk = 0;
            m_ext = 0;
        end
        chk("scan_valid_pulses", sv_cnt - sv0, good ? 1 : 0);
        chk("frame_err_pulses", fe_cnt - fe0, good ? 0 : 1);
        chk("scan_code", scan_code, m_code);
        chk("key_status", key_status, m_ks);
        chk("any_key", any_key, |m_ks);
    endtask

    initial begin
        int t0, fe0, delta;
        bit seen;
        logic [7:0] b;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_keys", key_status, 0);
        chk("rst_any", any_key, 0);
        chk("rst_code", scan_code, 0);
        chk("rst_sv", scan_valid, 0);
        chk("rst_fe", frame_err, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // reset in the middle of a frame, with a key already held
        xfer(8'h1A, 0, 0, -1);
        send(8'h1C, 0, 0, 5, -1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_keys", key_status, 0);
        chk("midrst_any", any_key, 0);
        chk("midrst_code", scan_code, 0);
        reset = 1'b0;
        m_ks = '0; m_code = '0; m_brk = 0; m_ext = 0;
        repeat (5) @(posedge clk);
        xfer(8'h1C, 0, 0, -1);

        // make / break sequences
        xfer(8'hF0, 0, 0, -1); xfer(8'h1C, 0, 0, -1);
        xfer(8'h1C, 0, 0, -1); xfer(8'h1A, 0, 0, -1);
        xfer(8'hF0, 0, 0, -1); xfer(8'h1C, 0, 0, -1);
        xfer(8'h1A, 0, 0, -1);
        xfer(8'hF0, 0, 0, -1); xfer(8'h32, 0, 0, -1);

        // corrupted frames
        xfer(8'h1C, 1, 0, -1); xfer(8'h1C, 0, 0, -1);
        xfer(8'hF0, 0, 1, -1); xfer(8'h1C, 0, 0, -1);

        // extended and unmapped codes
        xfer(8'hF0, 0, 0, -1); xfer(8'h1C, 0, 0, -1);
        xfer(8'hE0, 0, 0, -1); xfer(8'h1C, 0, 0, -1);
        xfer(8'hE0, 0, 0, -1); xfer(8'hF0, 0, 0, -1); xfer(8'h1C, 0, 0, -1);
        xfer(8'hF0, 0, 0, -1); xfer(8'h76, 0, 0, -1); xfer(8'h1C, 0, 0, -1);

        // timeout of a partial frame, with a break prefix pending
        xfer(8'hF0, 0, 0, -1);
        fe0 = fe_cnt;
        send(8'h15, 0, 0, 5, -1);
        t0 = last_fall;
        seen = 0;
        delta = 0;
        for (int i = 0; i < 8000 && !seen; i++) begin
            @(posedge clk);
            if (fe_cnt != fe0) begin
                seen = 1;
                delta = cyc - t0;
            end
        end
        chk("timeout_seen", seen, 1);
        chk("timeout_delay_ok", (delta >= 5000 && delta <= 5025), 1);
        repeat (50) @(posedge clk);
        chk("timeout_once", fe_cnt - fe0, 1);
        m_brk = 0; m_ext = 0;
        xfer(8'h15, 0, 0, -1);

        // clock glitches inside frames
        xfer(8'h2D, 0, 0, 3);
        xfer(8'h1B, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                5, 6:    b = 8'hF0;
                7:       b = 8'hE0;
                8:       b = 8'($urandom);
                default: b = lut[$urandom_range(0, 25)];
            endcase
            xfer(b, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, -1);
        end

        chk("never_both", ovl, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
